// File: rtl/hps_fpga_keys_in.sv
`default_nettype none
// ============================================================================
// Module   : hps_fpga_keys_in
// Purpose  : Avalon-MM input port for pushbuttons/switches with edge capture
//            and a maskable level interrupt. Optional debounce filter is
//            built when HPS_FPGA_KEYS_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hps_fpga_keys_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync0_q, sync1_q, prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecapture_q, edgecapture_d;
    logic [WIDTH-1:0] filt, edge_w, clear_w;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = &{1'b0, writedata};

`ifdef HPS_FPGA_KEYS_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit only follows sync1 after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign filt = filt_q;
`else
    logic unused_dbc;
    assign unused_dbc = (DEBOUNCE_CYCLES > 0);
    assign filt       = sync1_q;
`endif

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign edge_w = filt & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign edge_w = ~filt & prev_q;
        end else begin : g_edge_any
            assign edge_w = filt ^ prev_q;
        end
    endgenerate

    always_comb begin
        irqmask_d = irqmask_q;
        clear_w   = '0;
        if (wr_en && address == 2'd1) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            clear_w = writedata[WIDTH-1:0];
        end
        // New edges are OR-ed in after the clear so they are never lost.
        edgecapture_d = (edgecapture_q & ~clear_w) | edge_w;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = filt;
            2'd1:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecapture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q       <= '0;
            sync1_q       <= '0;
            prev_q        <= '0;
            irqmask_q     <= '0;
            edgecapture_q <= '0;
            readdata_q    <= '0;
        end else begin
            sync0_q       <= in_port;
            sync1_q       <= sync0_q;
            prev_q        <= filt;
            irqmask_q     <= irqmask_d;
            edgecapture_q <= edgecapture_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecapture_q & irqmask_q);

endmodule
`default_nettype wire
